// File: rtl/sc_statemachine_screenseq_if.sv
// Bundles the player/house inputs and object/background control outputs of the
// screen sequencer. The master side is the surrounding game logic, and the slave side is the sequencer.
interface sc_statemachine_screenseq_if #(
  parameter int unsigned LOSS_W  = 8,
  parameter int unsigned MAP_W   = 4,
  parameter int unsigned LEVEL_W = 2
);
  logic                 SC_SCREENSEQ_startButton_InLow;
  logic [LOSS_W-1:0]    SC_SCREENSEQ_LOSS_InHigh;
  logic                 SC_SCREENSEQ_DONE_InHigh;
  logic                 SC_SCREENSEQ_clear_OutLow;
  logic                 SC_SCREENSEQ_load_OutLow;
  logic                 SC_SCREENSEQ_WAIT_OutHigh;
  logic [MAP_W-1:0]     SC_SCREENSEQ_MAPSELECTION;
  logic [LEVEL_W-1:0]   SC_SCREENSEQ_LEVEL;

  modport master (
    output SC_SCREENSEQ_startButton_InLow, SC_SCREENSEQ_LOSS_InHigh, SC_SCREENSEQ_DONE_InHigh,
    input  SC_SCREENSEQ_clear_OutLow, SC_SCREENSEQ_load_OutLow, SC_SCREENSEQ_WAIT_OutHigh,
           SC_SCREENSEQ_MAPSELECTION, SC_SCREENSEQ_LEVEL
  );

  modport slave (
    input  SC_SCREENSEQ_startButton_InLow, SC_SCREENSEQ_LOSS_InHigh, SC_SCREENSEQ_DONE_InHigh,
    output SC_SCREENSEQ_clear_OutLow, SC_SCREENSEQ_load_OutLow, SC_SCREENSEQ_WAIT_OutHigh,
           SC_SCREENSEQ_MAPSELECTION, SC_SCREENSEQ_LEVEL
  );
endinterface

// File: rtl/sc_statemachine_screenseq.sv
// Background/screen sequencer: owns the level counter, holds the informational
// screens for HOLD_CYCLES cycles, and edge-detects the synchronised start button.
// Optional macro SCREENSEQ_CONTINUE_EN: after a loss, retry the current level
// instead of restarting from level 0.
module sc_statemachine_screenseq #(
  parameter int unsigned LEVELS      = 3,
  parameter int unsigned LEVEL_W     = 2,
  parameter int unsigned LOSS_W      = 8,
  parameter int unsigned MAP_W       = 4,
  parameter int unsigned HOLD_CYCLES = 50000000,
  parameter int unsigned HOLD_W      = 26
) (
  input logic                         SC_SCREENSEQ_CLOCK_50,
  input logic                         SC_SCREENSEQ_RESET_InHigh,
  sc_statemachine_screenseq_if.slave  bus
);

  localparam logic [MAP_W-1:0]   MAP_IDLE  = '1;
  localparam logic [MAP_W-1:0]   MAP_LOSS  = '0;
  localparam logic [MAP_W-1:0]   MAP_WIN   = MAP_W'(1);
  localparam logic [MAP_W-1:0]   MAP_SCR0  = MAP_W'(2);
  localparam logic [MAP_W-1:0]   MAP_MAP0  = MAP_W'(2 + LEVELS);
  localparam logic [MAP_W-1:0]   MAP_STAY  = MAP_W'(2 + 2 * LEVELS);
  localparam logic [MAP_W-1:0]   MAP_PASS  = MAP_W'(3 + 2 * LEVELS);
  localparam logic [LEVEL_W-1:0] LEVEL_LAST = LEVEL_W'(LEVELS - 1);
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_CYCLES - 1);

  typedef enum logic [3:0] {
    ST_RESET, ST_START, ST_CHECK, ST_STAY, ST_INIT, ST_ARM,
    ST_SCREEN, ST_MAP, ST_PLAY, ST_PASS, ST_LOSS, ST_WIN
  } state_t;

  state_t               state_q, state_d;
  logic [LEVEL_W-1:0]   level_q, level_d;
  logic [HOLD_W-1:0]    hold_q, hold_d;
  logic                 sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
  logic                 clear_q, clear_d, load_q, load_d, wait_q, wait_d;
  logic [MAP_W-1:0]     map_q, map_d;
  logic [LOSS_W-1:0]    loss_c;
  logic                 press_c;
  logic                 hold_done_c;

  assign loss_c      = bus.SC_SCREENSEQ_LOSS_InHigh;
  assign press_c     = prev_q & ~sync2_q;
  assign hold_done_c = (hold_q == HOLD_LAST);

  // Next state, level/hold counters, and Moore output decode of the next state
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    hold_d  = '0;
    sync1_d = bus.SC_SCREENSEQ_startButton_InLow;
    sync2_d = sync1_q;
    prev_d  = sync2_q;

    case (state_q)
      ST_RESET:  state_d = ST_START;
      ST_START:  state_d = ST_CHECK;
      ST_CHECK: begin
        if (press_c)           state_d = ST_INIT;
        else if (|loss_c)      state_d = ST_LOSS;
        else if (bus.SC_SCREENSEQ_DONE_InHigh) state_d = ST_PASS;
        else                   state_d = ST_STAY;
      end
      ST_STAY:   state_d = ST_CHECK;
      ST_INIT: begin
        level_d = '0;
        state_d = ST_ARM;
      end
      ST_ARM:    if (sync2_q) state_d = ST_SCREEN;
      ST_SCREEN: begin
        if (hold_done_c) state_d = ST_MAP;
        else             hold_d  = hold_q + HOLD_W'(1);
      end
      ST_MAP: begin
        if (hold_done_c) state_d = ST_PLAY;
        else             hold_d  = hold_q + HOLD_W'(1);
      end
      ST_PLAY:   state_d = ST_CHECK;
      ST_PASS: begin
        if (level_q == LEVEL_LAST) begin
          state_d = ST_WIN;
        end else begin
          level_d = level_q + LEVEL_W'(1);
          state_d = ST_SCREEN;
        end
      end
      ST_LOSS: begin
        if (hold_done_c) begin
`ifdef SCREENSEQ_CONTINUE_EN
          state_d = ST_SCREEN;
`else
          state_d = ST_INIT;
`endif
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      ST_WIN: begin
        if (hold_done_c) begin
          level_d = '0;
          state_d = ST_START;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      default:   state_d = ST_CHECK;
    endcase

    clear_d = 1'b1;
    load_d  = 1'b1;
    wait_d  = 1'b0;
    map_d   = MAP_IDLE;
    case (state_d)
      ST_STAY:   map_d = MAP_STAY;
      ST_INIT:   clear_d = 1'b0;
      ST_SCREEN: begin
        load_d = 1'b0;
        wait_d = 1'b1;
        map_d  = MAP_SCR0 + MAP_W'(level_d);
      end
      ST_MAP: begin
        load_d = 1'b0;
        wait_d = 1'b1;
        map_d  = MAP_MAP0 + MAP_W'(level_d);
      end
      ST_PASS:   map_d = MAP_PASS;
      ST_LOSS: begin
        load_d = 1'b0;
        wait_d = 1'b1;
        map_d  = MAP_LOSS;
      end
      ST_WIN: begin
        load_d = 1'b0;
        wait_d = 1'b1;
        map_d  = MAP_WIN;
      end
      default: ;
    endcase
  end

  // All state, counters, synchroniser and registered outputs
  always_ff @(posedge SC_SCREENSEQ_CLOCK_50 or posedge SC_SCREENSEQ_RESET_InHigh) begin
    if (SC_SCREENSEQ_RESET_InHigh) begin
      state_q <= ST_RESET;
      level_q <= '0;
      hold_q  <= '0;
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      clear_q <= 1'b1;
      load_q  <= 1'b1;
      wait_q  <= 1'b0;
      map_q   <= MAP_IDLE;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      hold_q  <= hold_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      clear_q <= clear_d;
      load_q  <= load_d;
      wait_q  <= wait_d;
      map_q   <= map_d;
    end
  end

  assign bus.SC_SCREENSEQ_clear_OutLow = clear_q;
  assign bus.SC_SCREENSEQ_load_OutLow  = load_q;
  assign bus.SC_SCREENSEQ_WAIT_OutHigh = wait_q;
  assign bus.SC_SCREENSEQ_MAPSELECTION = map_q;
  assign bus.SC_SCREENSEQ_LEVEL        = level_q;

endmodule

// File: tb/tb_sc_statemachine_screenseq.sv
// Directed bench for the screen sequencer with LEVELS=3, HOLD_CYCLES=4.
module tb_sc_statemachine_screenseq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   passed = 0;
  int   total  = 0;
  int   cur;

  always #5 clk = ~clk;

  sc_statemachine_screenseq_if #(.LOSS_W(8), .MAP_W(4), .LEVEL_W(2)) bus ();

  sc_statemachine_screenseq #(
    .LEVELS(3), .LEVEL_W(2), .LOSS_W(8), .MAP_W(4), .HOLD_CYCLES(4), .HOLD_W(3)
  ) dut (
    .SC_SCREENSEQ_CLOCK_50     (clk),
    .SC_SCREENSEQ_RESET_InHigh (rst),
    .bus                       (bus)
  );

  typedef struct packed {
    logic       rst;
    logic       btn;
    logic [7:0] loss;
    logic       done;
    logic       clr;
    logic       ld;
    logic       wt;
    logic [3:0] map;
    logic [1:0] lvl;
  } vec_t;

  vec_t vecs [24];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // lvl < 0 means the level is not compared for this step
  task automatic chk(input string nm, input logic clr, input logic ld, input logic wt,
                     input logic [3:0] map, input int lvl);
    logic ok;
    ok = (bus.SC_SCREENSEQ_clear_OutLow === clr) && (bus.SC_SCREENSEQ_load_OutLow === ld) &&
         (bus.SC_SCREENSEQ_WAIT_OutHigh === wt) && (bus.SC_SCREENSEQ_MAPSELECTION === map);
    if (lvl >= 0 && bus.SC_SCREENSEQ_LEVEL !== 2'(lvl)) ok = 1'b0;
    total++;
    if (ok) passed++;
    else $display("FAIL %s: got clr=%b ld=%b wt=%b map=%0d lvl=%0d, want clr=%b ld=%b wt=%b map=%0d lvl=%0d",
                  nm, bus.SC_SCREENSEQ_clear_OutLow, bus.SC_SCREENSEQ_load_OutLow,
                  bus.SC_SCREENSEQ_WAIT_OutHigh, bus.SC_SCREENSEQ_MAPSELECTION,
                  bus.SC_SCREENSEQ_LEVEL, clr, ld, wt, map, lvl);
  endtask

  task automatic hold_chk(input string nm, input logic [3:0] map, input int lvl, input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      chk(nm, 1'b1, 1'b0, 1'b1, map, lvl);
    end
  endtask

  // From CHECK at level lv: one pass, next level's screen and map, play, back to CHECK
  task automatic do_pass(input int lv);
    bus.SC_SCREENSEQ_DONE_InHigh = 1'b1;
    tick();
    chk("pass", 1'b1, 1'b1, 1'b0, 4'd9, lv);
    bus.SC_SCREENSEQ_DONE_InHigh = 1'b0;
    hold_chk("pass_screen", 4'(3 + lv), lv + 1, 4);
    hold_chk("pass_map", 4'(6 + lv), lv + 1, 4);
    tick();
    chk("pass_play", 1'b1, 1'b1, 1'b0, 4'd15, lv + 1);
    tick();
    chk("pass_check", 1'b1, 1'b1, 1'b0, 4'd15, lv + 1);
  endtask

  initial begin
    bus.SC_SCREENSEQ_startButton_InLow = 1'b1;
    bus.SC_SCREENSEQ_LOSS_InHigh       = 8'h00;
    bus.SC_SCREENSEQ_DONE_InHigh       = 1'b0;

    // Reset, idle alternation, then a 6-cycle button press through SCREEN/MAP/PLAY
    vecs[0]  = '{1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 4'd15, 2'd0};
    vecs[1]  = '{1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 4'd15, 2'd0};
    vecs[2]  = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 4'd15, 2'd0};
    vecs[3]  = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 4'd15, 2'd0};
    vecs[4]  = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 4'd8,  2'd0};
    vecs[5]  = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 4'd15, 2'd0};
    vecs[6]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 4'd8,  2'd0};
    vecs[7]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 4'd15, 2'd0};
    vecs[8]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 4'd15, 2'd0};
    vecs[9]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 4'd15, 2'd0};
    vecs[10] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 4'd15, 2'd0};
    vecs[11] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 4'd15, 2'd0};
    vecs[12] = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 4'd15, 2'd0};
    vecs[13] = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 4'd15, 2'd0};
    vecs[14] = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 4'd2,  2'd0};
    vecs[15] = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 4'd2,  2'd0};
    vecs[16] = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 4'd2,  2'd0};
    vecs[17] = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 4'd2,  2'd0};
    vecs[18] = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 4'd5,  2'd0};
    vecs[19] = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 4'd5,  2'd0};
    vecs[20] = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 4'd5,  2'd0};
    vecs[21] = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 4'd5,  2'd0};
    vecs[22] = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 4'd15, 2'd0};
    vecs[23] = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 4'd15, 2'd0};

    for (int i = 0; i < 24; i++) begin
      rst                                = vecs[i].rst;
      bus.SC_SCREENSEQ_startButton_InLow = vecs[i].btn;
      bus.SC_SCREENSEQ_LOSS_InHigh       = vecs[i].loss;
      bus.SC_SCREENSEQ_DONE_InHigh       = vecs[i].done;
      tick();
      chk($sformatf("vec%0d", i), vecs[i].clr, vecs[i].ld, vecs[i].wt, vecs[i].map, int'(vecs[i].lvl));
    end

    // Three passes: levels 0->1->2, then WIN and back to START with level 0
    do_pass(0);
    do_pass(1);
    bus.SC_SCREENSEQ_DONE_InHigh = 1'b1;
    tick();
    chk("last_pass", 1'b1, 1'b1, 1'b0, 4'd9, 2);
    bus.SC_SCREENSEQ_DONE_InHigh = 1'b0;
    hold_chk("win", 4'd1, 2, 4);
    tick();
    chk("win_start", 1'b1, 1'b1, 1'b0, 4'd15, 0);
    tick();
    chk("win_check", 1'b1, 1'b1, 1'b0, 4'd15, 0);

    // Reach level 1, then LOSS and DONE together in CHECK
    do_pass(0);
    bus.SC_SCREENSEQ_LOSS_InHigh = 8'h10;
    bus.SC_SCREENSEQ_DONE_InHigh = 1'b1;
    tick();
    chk("loss_priority", 1'b1, 1'b0, 1'b1, 4'd0, 1);
    bus.SC_SCREENSEQ_LOSS_InHigh = 8'h00;
    bus.SC_SCREENSEQ_DONE_InHigh = 1'b0;
    hold_chk("loss_hold", 4'd0, 1, 3);
`ifdef SCREENSEQ_CONTINUE_EN
    tick();
    chk("loss_retry_screen", 1'b1, 1'b0, 1'b1, 4'd3, 1);
    cur = 1;
`else
    tick();
    chk("loss_init", 1'b0, 1'b1, 1'b0, 4'd15, -1);
    tick();
    chk("loss_arm", 1'b1, 1'b1, 1'b0, 4'd15, 0);
    tick();
    chk("loss_screen", 1'b1, 1'b0, 1'b1, 4'd2, 0);
    cur = 0;
`endif

    // Button press and LOSS during SCREEN are ignored and not replayed
    bus.SC_SCREENSEQ_startButton_InLow = 1'b0;
    bus.SC_SCREENSEQ_LOSS_InHigh       = 8'hFF;
    tick();
    chk("ign_screen2", 1'b1, 1'b0, 1'b1, 4'(2 + cur), cur);
    bus.SC_SCREENSEQ_startButton_InLow = 1'b1;
    tick();
    chk("ign_screen3", 1'b1, 1'b0, 1'b1, 4'(2 + cur), cur);
    bus.SC_SCREENSEQ_LOSS_InHigh = 8'h00;
    tick();
    chk("ign_screen4", 1'b1, 1'b0, 1'b1, 4'(2 + cur), cur);
    hold_chk("ign_map", 4'(5 + cur), cur, 4);
    tick();
    chk("ign_play", 1'b1, 1'b1, 1'b0, 4'd15, cur);
    tick();
    chk("ign_check", 1'b1, 1'b1, 1'b0, 4'd15, cur);
    tick();
    chk("no_replay_stay", 1'b1, 1'b1, 1'b0, 4'd8, cur);
    tick();
    chk("no_replay_check", 1'b1, 1'b1, 1'b0, 4'd15, cur);

    // Asynchronous reset in the middle of MAP
    bus.SC_SCREENSEQ_DONE_InHigh = 1'b1;
    tick();
    chk("rst_pass", 1'b1, 1'b1, 1'b0, 4'd9, cur);
    bus.SC_SCREENSEQ_DONE_InHigh = 1'b0;
    hold_chk("rst_screen", 4'(3 + cur), cur + 1, 4);
    hold_chk("rst_map", 4'(6 + cur), cur + 1, 2);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async", 1'b1, 1'b1, 1'b0, 4'd15, 0);
    tick();
    chk("rst_held", 1'b1, 1'b1, 1'b0, 4'd15, 0);
    rst = 1'b0;
    tick();
    chk("rst_start", 1'b1, 1'b1, 1'b0, 4'd15, 0);
    tick();
    chk("rst_check", 1'b1, 1'b1, 1'b0, 4'd15, 0);
    tick();
    chk("rst_stay", 1'b1, 1'b1, 1'b0, 4'd8, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
